btn_ctrl: RTL and testbench
===========================

BTN_CTRL -- requirements
Module: btn_ctrl

Interface
REQ-001 The block SHALL have the following parameters:
  DEB_MS, 20, debounce stable time in CE1 ticks (range 2..255).
  REP_DLY_MS, 500, hold time before the first auto-repeat, in CE1 ticks (range 2..1023).
  REP_RATE_MS, 200, auto-repeat period in CE1 ticks (range 2..1023).
REQ-002 The block SHALL have the following ports:
  CLK   in   1  system clock, 100 MHz, all flops on rising edge.
  RST   in   1  reset, asynchronous, active-high.
  CE1   in   1  1 ms clock enable, one CLK cycle high per ms.
  KEYH  in   1  raw hour button, asynchronous, high = pressed.
  KEYM  in   1  raw minute button, asynchronous, high = pressed.
  KEYC  in   1  raw clear button, asynchronous, high = pressed.
  SETH  out  1  hour-increment command, one-CLK pulse.
  SETM  out  1  minute-increment command, one-CLK pulse.
  SCLR  out  1  seconds/msec clear command, one-CLK pulse.

Function
REQ-003 Each KEYx SHALL pass through a 2-flop synchronizer giving S; S SHALL be the only form of the key used downstream.
REQ-004 Each key SHALL have a debounced level D and a counter DC. On each CE1 cycle: if S==D, then DC<=0. Otherwise DC increments. When DC==DEB_MS-1, D<=S and DC<=0.
REQ-005 The CE1 gating SHALL make a bounce shorter than DEB_MS ticks leave D unchanged. Any return of S to D SHALL restart the count.
REQ-006 Each key SHALL have an FSM with states IDLE, DELAY, REPEAT and a repeat counter RC of 10 bits.
REQ-007 IDLE -> DELAY: on the edge where D goes 0->1. The edge SHALL clear RC to 0 and emit one output pulse.
REQ-008 DELAY: on each CE1, RC increments. At RC==REP_DLY_MS-1 the FSM SHALL emit a pulse, set RC<=0 and go to REPEAT.
REQ-009 REPEAT: on each CE1, RC increments. At RC==REP_RATE_MS-1 the FSM SHALL emit a pulse and set RC<=0.
REQ-010 From DELAY or REPEAT, the FSM SHALL go to IDLE on the edge where D goes 1->0. Release SHALL emit no pulse.
REQ-011 An output SHALL be registered and high for exactly one CLK cycle, namely the cycle after the edge that emits the pulse. The output SHALL never be high on two consecutive cycles.
REQ-012 Latency from KEYx rising, when it then stays stable, to the output pulse SHALL be 2 CLK cycles plus the time to reach DEB_MS CE1 ticks plus 1 CLK cycle.
REQ-013 The KEYC path SHALL never leave DELAY by repeat. SCLR SHALL be emitted once per debounced press, regardless of hold length.
REQ-014 The three keys SHALL be independent. Simultaneous pulses on SETH, SETM and SCLR SHALL be allowed in the same cycle, with no priority and no suppression.
REQ-015 CE1 held low SHALL freeze all counters and FSM timing. The synchronizers SHALL keep running.
REQ-016 A CE1 pulse longer than one cycle SHALL count once per high CLK cycle, with no edge detection.

Reset
REQ-017 RST high SHALL asynchronously clear the synchronizers, D, DC, RC and the outputs to 0, and set every FSM to IDLE.
REQ-018 The outputs SETH, SETM and SCLR SHALL read 0 throughout reset and on the first cycle after RST falls.
REQ-019 If a key is held across reset deassertion, it SHALL be treated as a new press: one pulse after DEB_MS ticks, then normal repeat timing.
REQ-020 Reset mid-hold or mid-debounce SHALL discard the pending pulse without emitting it.

Configuration
REQ-021 With macro BTN_AUTOREP_EN defined, the REPEAT state and the DELAY->REPEAT transition SHALL be built for KEYH and KEYM.
REQ-022 With BTN_AUTOREP_EN undefined, the block SHALL build without RC and without REPEAT. Every key SHALL then emit exactly one pulse per debounced press. Port list and debounce timing SHALL be unchanged.

Verification
REQ-023 Clean press: KEYH high for 100 ms, defaults -> exactly one SETH pulse, 1 CLK wide, 20 CE1 ticks (+3 CLK) after the press. No pulse on release.
REQ-024 Bounce: KEYM toggles every 5 ms for 30 ms, then stays high for 100 ms -> exactly one SETM pulse, 20 ticks after the last edge. A 10 ms low glitch while held -> no extra pulse.
REQ-025 Auto-repeat: KEYH held 1000 ms with BTN_AUTOREP_EN -> SETH pulses at about 20, 520, 720 and 920 ms (4 total). Without the macro -> 1 pulse.
REQ-026 Clear, no repeat: KEYC held 1000 ms, KEYH and KEYM pressed at the same instant -> one SCLR pulse. SETH and SETM pulse in the same CLK cycle.
REQ-027 Reset mid-hold: KEYH held, RST pulsed at 600 ms for 5 CLK -> outputs 0 during reset. Next SETH pulse 20 ticks after RST falls, then the next 500 ticks later.

Source files
------------

// File: rtl/btn_ctrl.sv
// Three-button front end: synchronise, debounce and turn presses into one-cycle commands.
// Define BTN_AUTOREP_EN to build hold-to-repeat on the hour and minute keys.

module btn_key #(
  parameter int unsigned DEB_MS      = 20
`ifdef BTN_AUTOREP_EN
  ,
  parameter int unsigned REP_DLY_MS  = 500,
  parameter int unsigned REP_RATE_MS = 200,
  parameter bit          REP_EN      = 1'b1
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic key,
  output logic pulse
);

  localparam int unsigned DC_W = 8;

  logic            s_meta;
  logic            s;
  logic            d;
  logic [DC_W-1:0] dc;
  logic            flip_c;
  logic            rise_c;
  logic            fall_c;

  // Two-flop synchroniser; s is the only view of the key used below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
    end else begin
      s_meta <= key;
      s      <= s_meta;
    end
  end

  assign flip_c = ce && (s != d) && (dc == DC_W'(DEB_MS - 1));
  assign rise_c = flip_c && s;
  assign fall_c = flip_c && !s;

  // Debounce: any tick where s agrees with d restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d  <= 1'b0;
      dc <= '0;
    end else if (ce) begin
      if (s == d) begin
        dc <= '0;
      end else if (flip_c) begin
        d  <= s;
        dc <= '0;
      end else begin
        dc <= dc + DC_W'(1);
      end
    end
  end

`ifdef BTN_AUTOREP_EN
  localparam int unsigned RC_W = 10;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t          state;
  state_t          state_n;
  logic [RC_W-1:0] rc;
  logic [RC_W-1:0] rc_n;
  logic            pulse_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rc    <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      rc    <= rc_n;
      pulse <= pulse_n;
    end
  end

  // Release wins over a repeat tick landing on the same cycle.
  always_comb begin
    state_n = state;
    rc_n    = rc;
    pulse_n = 1'b0;
    case (state)
      IDLE: begin
        if (rise_c) begin
          state_n = DELAY;
          rc_n    = '0;
          pulse_n = 1'b1;
        end
      end
      DELAY: begin
        if (fall_c) begin
          state_n = IDLE;
        end else if (ce && REP_EN) begin
          if (rc == RC_W'(REP_DLY_MS - 1)) begin
            state_n = REPEAT;
            rc_n    = '0;
            pulse_n = 1'b1;
          end else begin
            rc_n = rc + RC_W'(1);
          end
        end
      end
      REPEAT: begin
        if (fall_c) begin
          state_n = IDLE;
        end else if (ce) begin
          if (rc == RC_W'(REP_RATE_MS - 1)) begin
            rc_n    = '0;
            pulse_n = 1'b1;
          end else begin
            rc_n = rc + RC_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
`else
  typedef enum logic {IDLE, DELAY} state_t;

  state_t state;
  state_t state_n;
  logic   pulse_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      pulse <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    pulse_n = 1'b0;
    case (state)
      IDLE: begin
        if (rise_c) begin
          state_n = DELAY;
          pulse_n = 1'b1;
        end
      end
      DELAY: begin
        if (fall_c) state_n = IDLE;
      end
    endcase
  end
`endif

endmodule

module btn_ctrl #(
  parameter int unsigned DEB_MS      = 20,
  parameter int unsigned REP_DLY_MS  = 500,
  parameter int unsigned REP_RATE_MS = 200
) (
  input  logic CLK,
  input  logic RST,
  input  logic CE1,
  input  logic KEYH,
  input  logic KEYM,
  input  logic KEYC,
  output logic SETH,
  output logic SETM,
  output logic SCLR
);

  localparam bit CFG_OK = (DEB_MS >= 2) && (DEB_MS <= 255) &&
                          (REP_DLY_MS >= 2) && (REP_DLY_MS <= 1023) &&
                          (REP_RATE_MS >= 2) && (REP_RATE_MS <= 1023);

  if (!CFG_OK) begin : g_bad_cfg
    $error("btn_ctrl: timing parameter out of range");
  end

`ifdef BTN_AUTOREP_EN
  btn_key #(.DEB_MS(DEB_MS), .REP_DLY_MS(REP_DLY_MS), .REP_RATE_MS(REP_RATE_MS), .REP_EN(1'b1))
    u_key_h (.clk(CLK), .rst(RST), .ce(CE1), .key(KEYH), .pulse(SETH));
  btn_key #(.DEB_MS(DEB_MS), .REP_DLY_MS(REP_DLY_MS), .REP_RATE_MS(REP_RATE_MS), .REP_EN(1'b1))
    u_key_m (.clk(CLK), .rst(RST), .ce(CE1), .key(KEYM), .pulse(SETM));
  // Clear never repeats: it fires once per press however long it is held.
  btn_key #(.DEB_MS(DEB_MS), .REP_DLY_MS(REP_DLY_MS), .REP_RATE_MS(REP_RATE_MS), .REP_EN(1'b0))
    u_key_c (.clk(CLK), .rst(RST), .ce(CE1), .key(KEYC), .pulse(SCLR));
`else
  btn_key #(.DEB_MS(DEB_MS))
    u_key_h (.clk(CLK), .rst(RST), .ce(CE1), .key(KEYH), .pulse(SETH));
  btn_key #(.DEB_MS(DEB_MS))
    u_key_m (.clk(CLK), .rst(RST), .ce(CE1), .key(KEYM), .pulse(SETM));
  btn_key #(.DEB_MS(DEB_MS))
    u_key_c (.clk(CLK), .rst(RST), .ce(CE1), .key(KEYC), .pulse(SCLR));
`endif

endmodule

// File: tb/tb_btn_ctrl.sv
// Scoreboard bench for btn_ctrl: one CE1 tick every 10 CLK, expected pulse edges queued per output.
// Expected edge for a press driven after edge P (P a multiple of 10) is P + 200.

module tb_btn_ctrl;

  logic CLK, RST, CE1, KEYH, KEYM, KEYC;
  logic SETH, SETM, SCLR;

  int    edge_no = 0;
  int    checks  = 0;
  int    errors  = 0;
  bit    ce_en   = 1'b1;
  int    exp_q [3][$];
  string nm [3] = '{"SETH", "SETM", "SCLR"};

  btn_ctrl dut (
    .CLK(CLK), .RST(RST), .CE1(CE1),
    .KEYH(KEYH), .KEYM(KEYM), .KEYC(KEYC),
    .SETH(SETH), .SETM(SETM), .SCLR(SCLR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) edge_no <= edge_no + 1;

  // CE1 is sampled high on every edge that is a multiple of 10.
  initial begin
    CE1 = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      CE1 = ce_en && (edge_no % 10 == 9);
    end
  end

  task automatic goto(input int e);
    while (edge_no < e) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input int idx, input int e);
    exp_q[idx].push_back(e);
  endtask

  task automatic chk_quiet(input string tag);
    checks++;
    if ({SETH, SETM, SCLR} !== 3'b000) begin
      errors++;
      $display("FAIL %s at edge %0d: outputs=%b required=000", tag, edge_no, {SETH, SETM, SCLR});
    end
  endtask

  // Monitor: every asserted output must match the head of its queue.
  always @(negedge CLK) begin
    logic [2:0] o;
    int         e;
    o = {SCLR, SETM, SETH};
    for (int i = 0; i < 3; i++) begin
      if (exp_q[i].size() > 0 && exp_q[i][0] < edge_no) begin
        checks++;
        errors++;
        e = exp_q[i].pop_front();
        $display("FAIL missed_%s: no pulse seen, required at edge %0d (now %0d)", nm[i], e, edge_no);
      end
      if (o[i]) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_%s: pulse at edge %0d, required none", nm[i], edge_no);
        end else begin
          e = exp_q[i].pop_front();
          if (e != edge_no) begin
            errors++;
            $display("FAIL timing_%s: pulse at edge %0d, required edge %0d", nm[i], edge_no, e);
          end
        end
      end
    end
  end

  initial begin
    RST  = 1'b1;
    KEYH = 1'b0;
    KEYM = 1'b0;
    KEYC = 1'b0;

    @(negedge CLK); chk_quiet("rst_hold");
    @(negedge CLK); chk_quiet("rst_hold");
    goto(3);
    RST = 1'b0;
    @(negedge CLK); chk_quiet("rst_release");

    // Clean hour press, 100 ms.
    goto(100);  KEYH = 1'b1; push(0, 300);
    goto(1100); KEYH = 1'b0;

    // Minute bounce every 5 ms, last edge at 2300, then a 10 ms glitch.
    push(1, 2500);
    for (int k = 0; k < 7; k++) begin
      goto(2000 + 50 * k);
      KEYM = (k % 2 == 0);
    end
    goto(2700); KEYM = 1'b0;
    goto(2800); KEYM = 1'b1;
    goto(3300); KEYM = 1'b0;

    // Hour held 1000 ms.
    goto(4000); KEYH = 1'b1; push(0, 4200);
`ifdef BTN_AUTOREP_EN
    push(0, 9200); push(0, 11200); push(0, 13200);
`endif
    goto(14000); KEYH = 1'b0;

    // All three pressed together, held 1000 ms; clear never repeats.
    goto(15000);
    KEYH = 1'b1; KEYM = 1'b1; KEYC = 1'b1;
    push(0, 15200); push(1, 15200); push(2, 15200);
`ifdef BTN_AUTOREP_EN
    push(0, 20200); push(0, 22200); push(0, 24200);
    push(1, 20200); push(1, 22200); push(1, 24200);
`endif
    goto(25000);
    KEYH = 1'b0; KEYM = 1'b0; KEYC = 1'b0;

    // Reset at 600 ms into a hold: key treated as a fresh press afterwards.
    goto(26000); KEYH = 1'b1; push(0, 26200);
`ifdef BTN_AUTOREP_EN
    push(0, 31200);
`endif
    goto(32000); RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); chk_quiet("rst_mid_hold");
    end
    goto(32005); RST = 1'b0;
    @(negedge CLK); chk_quiet("rst_fall");
    push(0, 32200);
`ifdef BTN_AUTOREP_EN
    push(0, 37200);
`endif
    goto(38000); KEYH = 1'b0;

    // CE1 frozen for 100 ms: debounce only starts counting once ticks resume at 41000.
    goto(39995); ce_en = 1'b0;
    goto(40000); KEYM = 1'b1; push(1, 41190);
    goto(40995); ce_en = 1'b1;
    goto(42000); KEYM = 1'b0;
    goto(42600);

    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL leftover_%s: %0d pulses outstanding, required 0", nm[i], exp_q[i].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
